// File: rtl/pixel_word_packer.sv
// Packs a byte-wide pixel stream into little-endian 32-bit words and queues them, with frame-end tagging, in a small FIFO.
// Optional PIXEL_WORD_PACKER_DROP_COUNT_EN adds a saturating 16-bit dropped-word counter output.
module pixel_word_packer #(
  parameter int FRAME_PIXELS = 784,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic        word_last,
  output logic        overflow
`ifdef PIXEL_WORD_PACKER_DROP_COUNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(FRAME_PIXELS);
  localparam logic [FCW-1:0] LAST_PIX = FCW'(FRAME_PIXELS - 1);
  localparam logic [AW:0]    DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  logic [1:0]     lane_q, lane_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic [23:0]    partial_q, partial_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [32:0]    mem_q [FIFO_DEPTH];

  logic push, pop, full, wr_en, drop, last_pix;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    pop        = (count_q != '0) && word_ready;
    push       = pixel_valid && (lane_q == 2'd3);
    full       = (count_q == DEPTH_C);
    wr_en      = push && (!full || pop);
    drop       = push && full && !pop;
    last_pix   = (frame_q == LAST_PIX);

    lane_d     = lane_q;
    frame_d    = frame_q;
    partial_d  = partial_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    // Counters advance on every accepted pixel, even when the completed word is dropped, so framing survives overflow.
    if (pixel_valid) begin
      lane_d  = lane_q + 2'd1;
      frame_d = last_pix ? '0 : frame_q + 1'b1;
      case (lane_q)
        2'd0:    partial_d[7:0]   = pixel;
        2'd1:    partial_d[15:8]  = pixel;
        2'd2:    partial_d[23:16] = pixel;
        default: partial_d        = '0;
      endcase
    end

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value of its peers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q     <= '0;
      frame_q    <= '0;
      partial_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      frame_q    <= frame_d;
      partial_q  <= partial_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: FIFO storage is not reset; the head is only visible while occupancy is non-zero, which reset clears.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {last_pix, pixel, partial_q};
  end

  assign word_valid = (count_q != '0);
  assign word_data  = word_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign word_last  = word_valid & mem_q[rd_ptr_q][32];
  assign overflow   = overflow_q;

`ifdef PIXEL_WORD_PACKER_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// Self-checking bench for pixel_word_packer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pixel_word_packer;

  localparam int FP    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_valid;
  logic [7:0]  pixel;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_last;
  logic        overflow;
`ifdef PIXEL_WORD_PACKER_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  pixel_word_packer #(.FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_valid(pixel_valid),
    .pixel      (pixel),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .overflow   (overflow)
`ifdef PIXEL_WORD_PACKER_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a byte list for the partial word, a pixel index within the frame, and a bounded word queue.
  logic [7:0]  pend [$];
  logic [32:0] wq   [$];
  int          pix_idx;
  logic        m_ovf;
  int          m_drops;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    wq.delete();
    pix_idx = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_outputs();
    logic [32:0] head;
    head = (wq.size() > 0) ? wq[0] : 33'h0;
    check("word_valid", word_valid, wq.size() > 0);
    check("word_data",  word_data,  head[31:0]);
    check("word_last",  word_last,  head[32]);
    check("overflow",   overflow,   m_ovf);
`ifdef PIXEL_WORD_PACKER_DROP_COUNT_EN
    check("drop_count", drop_count, m_drops);
`endif
  endtask

  // One clock cycle: drive at the falling edge, compare against the model, then advance the model across the rising edge.
  task automatic step(input logic v, input logic [7:0] p, input logic r);
    logic        do_pop;
    logic [32:0] w;
    @(negedge clk);
    pixel_valid = v;
    pixel       = p;
    word_ready  = r;
    check_outputs();
    do_pop = (wq.size() > 0) && r;
    if (do_pop) void'(wq.pop_front());
    if (v) begin
      pend.push_back(p);
      if (pend.size() == 4) begin
        w = {(pix_idx == FP - 1), pend[3], pend[2], pend[1], pend[0]};
        pend.delete();
        if (wq.size() < DEPTH) begin
          wq.push_back(w);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      pix_idx = (pix_idx + 1) % FP;
    end
    @(posedge clk);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] d, input logic l);
    #1;
    check({tag, "_valid"}, word_valid, 1'b1);
    check({tag, "_data"},  word_data,  d);
    check({tag, "_last"},  word_last,  l);
  endtask

  // Asserts reset between edges so the asynchronous clear is observable before any clock.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_valid",    word_valid, 1'b0);
    check("rst_data",     word_data,  32'h0);
    check("rst_last",     word_last,  1'b0);
    check("rst_overflow", overflow,   1'b0);
    model_reset();
    @(negedge clk);
    pixel_valid = 1'b0;
    reset       = 1'b1;
  endtask

  logic [7:0] pat [4];

  initial begin
    reset       = 1'b0;
    pixel_valid = 1'b0;
    pixel       = 8'h00;
    word_ready  = 1'b0;
    model_reset();
    #12;
    check("init_valid",    word_valid, 1'b0);
    check("init_data",     word_data,  32'h0);
    check("init_overflow", overflow,   1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back pixels into an empty FIFO.
    pat = '{8'h00, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b1);
    expect_head("b2b", 32'h33221100, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    #1 check("b2b_single", word_valid, 1'b0);

    // Alternating pixel_valid completes the second word of the frame, which is the last one.
    pat = '{8'h44, 8'h55, 8'h66, 8'h77};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 1'b1);
      if (i < 3) step(1'b0, 8'hEE, 1'b1);
    end
    expect_head("alt", 32'h77665544, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Two frames of eight pixels: word_last pattern 0,1,0,1.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i + 8'h80), 1'b1);
      if (i % 4 == 3)
        expect_head("frame", {8'(i + 8'h80), 8'(i + 8'h7F), 8'(i + 8'h7E), 8'(i + 8'h7D)}, (i % 8 == 7));
    end
    step(1'b0, 8'h00, 1'b1);

    // Stalled sink: four words fill the FIFO, the fifth is dropped, then the first four drain in order.
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0);
    #1;
    check("ovf_set",  overflow,  1'b1);
    check("ovf_head", word_data, 32'h03020100);
`ifdef PIXEL_WORD_PACKER_DROP_COUNT_EN
    check("ovf_drops", drop_count, 16'd1);
`endif
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    #1 check("ovf_drained", word_valid, 1'b0);

    // Full FIFO popped in the same cycle a word completes: nothing is dropped.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i + 8'h40), 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b1, 8'(i + 8'h50), 1'b0);
    step(1'b1, 8'h53, 1'b1);
    #1;
    check("fullpop_ovf",  overflow,  1'b0);
    check("fullpop_head", word_data, 32'h47464544);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);

    // Reset mid-frame discards queued and partial words.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(i + 8'h10), 1'b0);
    do_reset();
    pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b1);
    expect_head("post_rst", 32'hDDCCBBAA, 1'b0);

    // Randomized traffic with varying sink throughput and occasional resets.
    for (int blk = 0; blk < 8; blk++) begin
      int bias;
      bias = $urandom_range(0, 3);
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 399) == 0) do_reset();
        step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) >= bias);
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
